line_xfer_engine: RTL and testbench

- Memory-side line transfer engine of the 2-way set-associative LRU cache controller; sits directly upstream of boseben_ram and drives its mem_we/mem_re/mem_addr/mem_data_in port.
- On a miss, the controller hands it one request: optional writeback of the evicted dirty line, then optional fill of the new line.
- The engine sequences these as word-by-word RAM accesses. It returns fill words to the cache data array and pulses done when the request is complete.

---
 rtl/line_xfer_engine_if.sv | 48 ++++
 rtl/line_xfer_engine.sv | 174 +++++++++++++++++
 tb/tb_line_xfer_engine.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/line_xfer_engine_if.sv
// Bus bundle between the cache controller, the line transfer engine and the RAM.
// It carries the request handshake, the cache word ports and the RAM port.
interface line_xfer_engine_if #(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
);
  localparam int IDX_W = $clog2(WORDS_PER_LINE);

  // Request handshake from the controller.
  logic              req_valid;
  logic              req_ready;
  logic              req_wb;
  logic              req_fill;
  logic [ADDR_W-1:0] wb_addr;
  logic [ADDR_W-1:0] fill_addr;

  // Cache data array side.
  logic [IDX_W-1:0]  wb_word_idx;
  logic [31:0]       wb_word_in;
  logic              fill_word_valid;
  logic [IDX_W-1:0]  fill_word_idx;
  logic [31:0]       fill_word_data;

  // Status.
  logic              done;
  logic              busy;

  // RAM port.
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data_in;
  logic [31:0]       mem_data_out;

  // Engine side.
  modport slave (
    input  req_valid, req_wb, req_fill, wb_addr, fill_addr, wb_word_in, mem_data_out,
    output req_ready, wb_word_idx, fill_word_valid, fill_word_idx, fill_word_data,
           done, busy, mem_we, mem_re, mem_addr, mem_data_in
  );

  // Controller / RAM side.
  modport master (
    output req_valid, req_wb, req_fill, wb_addr, fill_addr, wb_word_in, mem_data_out,
    input  req_ready, wb_word_idx, fill_word_valid, fill_word_idx, fill_word_data,
           done, busy, mem_we, mem_re, mem_addr, mem_data_in
  );
endinterface

// File: rtl/line_xfer_engine.sv
// Memory-side line transfer engine of the 2-way LRU cache controller.
// One request = optional writeback of the victim line, then optional fill of the
// new line, sequenced as word-by-word accesses to a big-endian byte RAM whose
// read data arrives one cycle after the read address.
module line_xfer_engine #(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input logic               clk,
  input logic               rst,
  line_xfer_engine_if.slave bus
);

  localparam int IDX_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W = $clog2(4 * WORDS_PER_LINE);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [CNT_W-1:0]  LAST_WB   = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0]  LAST_FILL = CNT_W'(WORDS_PER_LINE);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'((64'd1 << OFF_W) - 64'd1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_fill;
  logic [ADDR_W-1:0] r_wbBase;
  logic [ADDR_W-1:0] r_fillBase;

  logic              w_accept;
  logic [IDX_W-1:0]  w_wbIdx;
  logic [IDX_W-1:0]  w_fillAddrIdx;
  logic [IDX_W-1:0]  w_fillPrevIdx;

  // Word i of a line sits at B + 4*i + 3: the RAM takes the address of the
  // least significant byte and stores the MSB three bytes below it.
  function automatic logic [ADDR_W-1:0] wordOffset(input logic [IDX_W-1:0] idx);
    return ADDR_W'({idx, 2'b11});
  endfunction

  assign w_accept = bus.req_valid && (r_state == S_IDLE);
  assign w_wbIdx  = r_cnt[IDX_W-1:0];

  // The fill counter runs one step past the last word to collect the final read;
  // that extra cycle reissues the last address (counter MSB set only at j=N).
  assign w_fillAddrIdx = r_cnt[IDX_W] ? {IDX_W{1'b1}} : r_cnt[IDX_W-1:0];

  // Read data seen now belongs to the address issued one cycle earlier.
  assign w_fillPrevIdx = IDX_W'(r_cnt - CNT_W'(1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state selection: writeback first, then fill, then the done pulse.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.req_wb) begin
            w_nextState = S_WB;
          end else if (bus.req_fill) begin
            w_nextState = S_FILL;
          end else begin
            w_nextState = S_DONE;
          end
        end
      end
      S_WB: begin
        if (r_cnt == LAST_WB) begin
          w_nextState = r_fill ? S_FILL : S_DONE;
        end
      end
      S_FILL: begin
        if (r_cnt == LAST_FILL) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Request latch on accept and the per-phase word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_fill     <= 1'b0;
      r_wbBase   <= '0;
      r_fillBase <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_accept) begin
            r_fill     <= bus.req_fill;
            r_wbBase   <= bus.wb_addr & LINE_MASK;
            r_fillBase <= bus.fill_addr & LINE_MASK;
          end
        end
        S_WB: begin
          r_cnt <= (r_cnt == LAST_WB) ? '0 : r_cnt + CNT_W'(1);
        end
        S_FILL: begin
          r_cnt <= (r_cnt == LAST_FILL) ? '0 : r_cnt + CNT_W'(1);
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Output decode; every output idles at zero outside the phase that uses it.
  always_comb begin
    bus.req_ready       = 1'b0;
    bus.busy            = 1'b0;
    bus.done            = 1'b0;
    bus.mem_we          = 1'b0;
    bus.mem_re          = 1'b0;
    bus.mem_addr        = '0;
    bus.mem_data_in     = '0;
    bus.wb_word_idx     = '0;
    bus.fill_word_valid = 1'b0;
    bus.fill_word_idx   = '0;
    bus.fill_word_data  = '0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
      end
      S_WB: begin
        bus.busy        = 1'b1;
        bus.mem_we      = 1'b1;
        bus.wb_word_idx = w_wbIdx;
        bus.mem_addr    = r_wbBase + wordOffset(w_wbIdx);
        bus.mem_data_in = bus.wb_word_in;
      end
      S_FILL: begin
        bus.busy     = 1'b1;
        bus.mem_re   = 1'b1;
        bus.mem_addr = r_fillBase + wordOffset(w_fillAddrIdx);
        if (r_cnt != '0) begin
          bus.fill_word_valid = 1'b1;
          bus.fill_word_idx   = w_fillPrevIdx;
          bus.fill_word_data  = bus.mem_data_out;
        end
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_line_xfer_engine.sv
// Directed testbench for line_xfer_engine with a big-endian byte RAM model and
// a combinational victim-word source standing in for the cache data array.
module tb_line_xfer_engine;

  localparam int N  = 4;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [7:0]  ram [0:4095];
  logic [31:0] ramDataOut = 'z;
  logic [11:0] ramAddr;
  logic [31:0] wbPattern = 32'h0;

  logic [31:0] lowWords  [N];
  logic [31:0] highWords [N];

  line_xfer_engine_if #(.WORDS_PER_LINE(N), .ADDR_W(AW)) bus ();

  line_xfer_engine #(.WORDS_PER_LINE(N), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign ramAddr          = bus.mem_addr[11:0];
  assign bus.mem_data_out = ramDataOut;
  assign bus.wb_word_in   = wbPattern + 32'(bus.wb_word_idx);

  // RAM model: driven address names the LSB byte, MSB lives three bytes lower;
  // read data is registered and floats when no read is issued.
  always @(posedge clk) begin
    if (bus.mem_we && !bus.mem_re) begin
      ram[ramAddr - 12'd3] <= bus.mem_data_in[31:24];
      ram[ramAddr - 12'd2] <= bus.mem_data_in[23:16];
      ram[ramAddr - 12'd1] <= bus.mem_data_in[15:8];
      ram[ramAddr]         <= bus.mem_data_in[7:0];
    end
    if (bus.mem_re && !bus.mem_we) begin
      ramDataOut <= {ram[ramAddr - 12'd3], ram[ramAddr - 12'd2], ram[ramAddr - 12'd1], ram[ramAddr]};
    end else begin
      ramDataOut <= 'z;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge of the first cycle after accept.
  task automatic applyStimulus(input logic wb, input logic fill, input logic [31:0] wbA, input logic [31:0] fillA);
    bus.req_valid = 1'b1;
    bus.req_wb    = wb;
    bus.req_fill  = fill;
    bus.wb_addr   = wbA;
    bus.fill_addr = fillA;
    checkOutput("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wb    = 1'b0;
    bus.req_fill  = 1'b0;
    bus.wb_addr   = 32'hFFFF_FFFF;
    bus.fill_addr = 32'hFFFF_FFFF;
  endtask

  task automatic expectWb(input string tag, input logic [31:0] base, input logic [31:0] pattern);
    for (int i = 0; i < N; i++) begin
      checkOutput({tag, "_wb_we"},   32'(bus.mem_we), 32'd1);
      checkOutput({tag, "_wb_re"},   32'(bus.mem_re), 32'd0);
      checkOutput({tag, "_wb_addr"}, bus.mem_addr, base + 32'(4 * i + 3));
      checkOutput({tag, "_wb_data"}, bus.mem_data_in, pattern + 32'(i));
      checkOutput({tag, "_wb_idx"},  32'(bus.wb_word_idx), 32'(i));
      checkOutput({tag, "_wb_done"}, 32'(bus.done), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic expectFill(input string tag, input logic [31:0] base, input logic [31:0] words [N]);
    int ai;
    for (int j = 0; j <= N; j++) begin
      ai = (j < N) ? j : N - 1;
      checkOutput({tag, "_fill_re"},    32'(bus.mem_re), 32'd1);
      checkOutput({tag, "_fill_we"},    32'(bus.mem_we), 32'd0);
      checkOutput({tag, "_fill_addr"},  bus.mem_addr, base + 32'(4 * ai + 3));
      checkOutput({tag, "_fill_valid"}, 32'(bus.fill_word_valid), 32'(j >= 1));
      if (j >= 1) begin
        checkOutput({tag, "_fill_idx"},  32'(bus.fill_word_idx), 32'(j - 1));
        checkOutput({tag, "_fill_data"}, bus.fill_word_data, words[j - 1]);
      end
      checkOutput({tag, "_fill_done"}, 32'(bus.done), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic expectDone(input string tag);
    checkOutput({tag, "_done"},      32'(bus.done), 32'd1);
    checkOutput({tag, "_done_we"},   32'(bus.mem_we), 32'd0);
    checkOutput({tag, "_done_re"},   32'(bus.mem_re), 32'd0);
    checkOutput({tag, "_done_addr"}, bus.mem_addr, 32'd0);
    checkOutput({tag, "_done_fv"},   32'(bus.fill_word_valid), 32'd0);
    checkOutput({tag, "_done_busy"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    checkOutput({tag, "_after_done"},  32'(bus.done), 32'd0);
    checkOutput({tag, "_after_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  // Directed sequence: reset, idle, fill, writeback, both, neither, reset mid-fill.
  initial begin
    bus.req_valid = 1'b0;
    bus.req_wb    = 1'b0;
    bus.req_fill  = 1'b0;
    bus.wb_addr   = '0;
    bus.fill_addr = '0;
    for (int k = 0; k < 4096; k++) ram[k] = 8'h00;
    for (int k = 0; k < 16; k++) begin
      ram[12'h100 + 12'(k)] = 8'(k);
      ram[12'h400 + 12'(k)] = 8'(8'h40 + k);
    end
    lowWords  = '{32'h0001_0203, 32'h0405_0607, 32'h0809_0A0B, 32'h0C0D_0E0F};
    highWords = '{32'h4041_4243, 32'h4445_4647, 32'h4849_4A4B, 32'h4C4D_4E4F};

    // Reset held for three cycles.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready",   32'(bus.req_ready), 32'd1);
    checkOutput("rst_busy",        32'(bus.busy), 32'd0);
    checkOutput("rst_done",        32'(bus.done), 32'd0);
    checkOutput("rst_we",          32'(bus.mem_we), 32'd0);
    checkOutput("rst_re",          32'(bus.mem_re), 32'd0);
    checkOutput("rst_addr",        bus.mem_addr, 32'd0);
    checkOutput("rst_data_in",     bus.mem_data_in, 32'd0);
    checkOutput("rst_fill_valid",  32'(bus.fill_word_valid), 32'd0);
    checkOutput("rst_fill_idx",    32'(bus.fill_word_idx), 32'd0);
    checkOutput("rst_fill_data",   bus.fill_word_data, 32'd0);
    checkOutput("rst_wb_idx",      32'(bus.wb_word_idx), 32'd0);
    rst = 1'b0;

    // Idle for five cycles with nothing requested.
    repeat (5) begin
      @(negedge clk);
      checkOutput("idle_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("idle_we",    32'(bus.mem_we), 32'd0);
      checkOutput("idle_re",    32'(bus.mem_re), 32'd0);
      checkOutput("idle_busy",  32'(bus.busy), 32'd0);
    end

    $display("[TB] fill only");
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0000_010C);
    expectFill("fill", 32'h0000_0100, lowWords);
    expectDone("fill");

    $display("[TB] writeback only");
    wbPattern = 32'hA000_0000;
    applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    expectWb("wb", 32'h0000_0200, wbPattern);
    expectDone("wb");
    checkOutput("wb_ram_204", 32'(ram[12'h204]), 32'h0000_00A0);
    checkOutput("wb_ram_207", 32'(ram[12'h207]), 32'h0000_0001);
    checkOutput("wb_ram_20f", 32'(ram[12'h20F]), 32'h0000_0003);

    $display("[TB] writeback then fill");
    @(negedge clk);
    wbPattern = 32'hB000_0000;
    applyStimulus(1'b1, 1'b1, 32'h0000_0305, 32'h0000_0400);
    expectWb("both", 32'h0000_0300, wbPattern);
    expectFill("both", 32'h0000_0400, highWords);
    expectDone("both");
    checkOutput("both_ram_300", 32'(ram[12'h300]), 32'h0000_00B0);
    checkOutput("both_ram_30f", 32'(ram[12'h30F]), 32'h0000_0003);

    $display("[TB] neither flag");
    applyStimulus(1'b0, 1'b0, 32'h0000_0500, 32'h0000_0600);
    expectDone("none");

    $display("[TB] reset during fill");
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0000_0100);
    @(negedge clk);
    checkOutput("rstfill_valid_j1", 32'(bus.fill_word_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rstfill_re",    32'(bus.mem_re), 32'd0);
    checkOutput("rstfill_valid", 32'(bus.fill_word_valid), 32'd0);
    checkOutput("rstfill_addr",  bus.mem_addr, 32'd0);
    checkOutput("rstfill_ready", 32'(bus.req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("rstfill_no_done", 32'(bus.done), 32'd0);
      checkOutput("rstfill_no_re",   32'(bus.mem_re), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0000_040C);
    expectFill("refill", 32'h0000_0400, highWords);
    expectDone("refill");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
